// File: rtl/tile_writeback_pkg.sv
// rtl/tile_writeback_pkg.sv - shared tile geometry and pixel type for the tile pipeline
package tile_writeback_pkg;

   localparam int TILE_DIM    = 32;
   localparam int TILE_PIXELS = TILE_DIM * TILE_DIM;
   localparam int TILE_IDX_W  = 10;

   // RGB565 pixel as stored in the tile RAM and the framebuffer
   typedef logic [15:0] pixel_t;

endpackage

// File: rtl/tile_writeback_pixel_skid_fifo.sv
// rtl/tile_writeback_pixel_skid_fifo.sv - 2-deep pixel FIFO hiding the tile RAM read latency
module pixel_skid_fifo
   import tile_writeback_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       push,
   input  pixel_t     push_data,
   input  logic       pop,
   output pixel_t     head,
   output logic       empty,
   output logic       full,
   output logic [1:0] count
);

   pixel_t mem [2];
   logic   wr_ptr;
   logic   rd_ptr;
   logic   do_push;
   logic   do_pop;

   // A pop frees the head slot, so a push is accepted even when full if it pairs with a pop
   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
   end

   assign empty = (count == 2'd0);
   assign full  = (count == 2'd2);
   assign head  = mem[rd_ptr];

   // Storage, pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tile_writeback.sv
// rtl/tile_writeback.sv - drains one 32x32 RGB565 tile into the linear framebuffer over Avalon-MM
module tile_writeback
   import tile_writeback_pkg::*;
#(
   parameter int FB_WIDTH = 640,
   parameter int ADDR_W   = 32
)
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [5:0]            tile_x,
   input  logic [5:0]            tile_y,
   input  logic [ADDR_W-1:0]     fb_base,
   output logic                  busy,
   output logic                  done,
   output logic [TILE_IDX_W-1:0] tile_addr,
   input  logic [15:0]           tile_data,
   output logic [ADDR_W-1:0]     avm_address,
   output logic                  avm_write,
   output logic [15:0]           avm_writedata,
   input  logic                  avm_waitrequest
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDR_W-1:0] LINE_PITCH = ADDR_W'(FB_WIDTH * 2);
   localparam logic [ADDR_W-1:0] TILE_ROW   = ADDR_W'(TILE_DIM * FB_WIDTH * 2);
   localparam logic [ADDR_W-1:0] TILE_COL   = ADDR_W'(TILE_DIM * 2);

   logic [1:0]            state;
   logic [ADDR_W-1:0]     line_base;
   logic [TILE_IDX_W:0]   rd_idx;
   logic [TILE_IDX_W-1:0] wr_idx;
   logic                  rd_inflight;
   logic                  rd_issue;
   logic                  accept;
   logic [2:0]            demand;

   logic                  fifo_push;
   logic                  fifo_pop;
   pixel_t                fifo_head;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [1:0]            fifo_count;

   pixel_skid_fifo u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (fifo_push),
      .push_data (tile_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign busy          = (state == ST_RUN);
   assign done          = (state == ST_DONE);
   assign avm_write     = ~fifo_empty;
   assign avm_writedata = fifo_head;
   assign avm_address   = line_base + ADDR_W'({wr_idx[4:0], 1'b0});

   // Read issue counts the slot freed by this cycle's pop so the pipe sustains one pixel per cycle
   always_comb begin
      accept    = avm_write & ~avm_waitrequest;
      fifo_pop  = accept;
      fifo_push = rd_inflight;
      demand    = {1'b0, fifo_count} + {2'b00, rd_inflight} - {2'b00, fifo_pop};
      rd_issue  = (state == ST_RUN) && (rd_idx < (TILE_IDX_W+1)'(TILE_PIXELS)) && (demand < 3'd2);
   end

   // FSM, read/write counters and framebuffer line accumulator
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         line_base   <= '0;
         rd_idx      <= '0;
         wr_idx      <= '0;
         rd_inflight <= 1'b0;
         tile_addr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_RUN;
                  line_base <= fb_base + ADDR_W'(tile_y) * TILE_ROW + ADDR_W'(tile_x) * TILE_COL;
                  rd_idx    <= '0;
                  wr_idx    <= '0;
               end
            end
            ST_RUN: begin
               if (accept && (wr_idx == TILE_IDX_W'(TILE_PIXELS - 1))) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         rd_inflight <= rd_issue;
         if (rd_issue) begin
            tile_addr <= rd_idx[TILE_IDX_W-1:0];
            rd_idx    <= rd_idx + 1'b1;
         end

         if (accept) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx[4:0] == 5'd31) begin
               line_base <= line_base + LINE_PITCH;
            end
         end
      end
   end

   // The read throttle must never let a push land on a full FIFO without a matching pop
   always @(posedge clk) begin
      if (resetn) begin
         assert (!(fifo_push && fifo_full && !fifo_pop));
      end
   end

endmodule

// File: tb/tb_tile_writeback.sv
// tb/tb_tile_writeback.sv - self-checking bench for tile_writeback against a framebuffer address model
module tb_tile_writeback;

   localparam int FBW = 640;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  tile_x = '0;
   logic [5:0]  tile_y = '0;
   logic [31:0] fb_base = '0;
   logic        busy;
   logic        done;
   logic [9:0]  tile_addr;
   logic [15:0] tile_data;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [15:0] avm_writedata;
   logic        avm_waitrequest = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [15:0] ram [1024];
   logic [31:0] wa [$];
   logic [15:0] wd [$];
   int          done_pulses = 0;
   int          stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [15:0] prev_data = '0;

   tile_writeback #(.FB_WIDTH(FBW), .ADDR_W(32)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .start           (start),
      .tile_x          (tile_x),
      .tile_y          (tile_y),
      .fb_base         (fb_base),
      .busy            (busy),
      .done            (done),
      .tile_addr       (tile_addr),
      .tile_data       (tile_data),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest)
   );

   always #5 clk = ~clk;

   assign tile_data = ram[tile_addr];

   // Record accepted writes, done pulses and any change on the bus while stalled
   always @(negedge clk) begin
      if (resetn) begin
         if (prev_stall && (avm_write !== 1'b1 || avm_address !== prev_addr || avm_writedata !== prev_data))
            stall_viol++;
         if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
            wa.push_back(avm_address);
            wd.push_back(avm_writedata);
         end
         if (done === 1'b1) done_pulses++;
         prev_stall = avm_write && avm_waitrequest;
         prev_addr  = avm_address;
         prev_data  = avm_writedata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic logic [31:0] exp_addr(logic [31:0] base, int tx, int ty, int i);
      return base + 32'(((ty * 32 + i / 32) * FBW + tx * 32 + i % 32) * 2);
   endfunction

   function automatic int count_bad(logic [31:0] base, int tx, int ty);
      int bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (i >= wa.size()) bad++;
         else if (wa[i] !== exp_addr(base, tx, ty, i) || wd[i] !== ram[i]) bad++;
      end
      if (wa.size() > 1024) bad += wa.size() - 1024;
      return bad;
   endfunction

   task automatic fill_ram(input bit ramp);
      for (int i = 0; i < 1024; i++) ram[i] = ramp ? 16'(i) : 16'($urandom);
   endtask

   task automatic do_start(input logic [5:0] tx, input logic [5:0] ty, input logic [31:0] base);
      @(negedge clk);
      wa.delete();
      wd.delete();
      done_pulses = 0;
      stall_viol  = 0;
      tile_x  = tx;
      tile_y  = ty;
      fb_base = base;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drain(input int mode, input int restart_at, input int stop_at,
                        output int first_wr, output int done_cyc, output logic busy1);
      int cyc = 0;
      bit restarted = 0;
      first_wr = -1;
      done_cyc = -1;
      busy1    = 1'b0;
      while (cyc < 6000) begin
         @(posedge clk);
         #1;
         cyc++;
         start = 1'b0;
         if (cyc == 1) busy1 = busy;
         if (first_wr < 0 && avm_write === 1'b1) first_wr = cyc;
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         if (stop_at >= 0 && wa.size() >= stop_at) break;
         if (restart_at >= 0 && !restarted && wa.size() >= restart_at) begin
            tile_x    = 6'd5;
            tile_y    = 6'd7;
            fb_base   = 32'h0;
            start     = 1'b1;
            restarted = 1;
         end
         avm_waitrequest = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      avm_waitrequest = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 6;
      if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0)         begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      if (avm_write !== 1'b0)    begin failures++; $display("FAIL reset_write: got %b expected 0", avm_write); end
      if (avm_address !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", avm_address); end
      if (avm_writedata !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", avm_writedata); end
      if (tile_addr !== 10'h0)   begin failures++; $display("FAIL reset_tile_addr: got %h expected 0", tile_addr); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_ramp_tile00();
      int fw, dc, bad;
      logic b1;
      fill_ram(1);
      avm_waitrequest = 1'b0;
      do_start(6'd0, 6'd0, 32'h0010_0000);
      drain(0, -1, -1, fw, dc, b1);
      repeat (4) @(posedge clk);
      bad = count_bad(32'h0010_0000, 0, 0);
      checks += 8;
      if (fw !== 2)    begin failures++; $display("FAIL t1_first_write_cycle: got %0d expected 2", fw); end
      if (dc !== 1026) begin failures++; $display("FAIL t1_done_cycle: got %0d expected 1026", dc); end
      if (b1 !== 1'b1) begin failures++; $display("FAIL t1_busy_cycle1: got %b expected 1", b1); end
      if (wa.size() !== 1024) begin failures++; $display("FAIL t1_write_count: got %0d expected 1024", wa.size()); end
      if (wa[33] !== 32'h0010_0502) begin failures++; $display("FAIL t1_px33_addr: got %h expected 00100502", wa[33]); end
      if (wd[33] !== 16'h0021) begin failures++; $display("FAIL t1_px33_data: got %h expected 0021", wd[33]); end
      if (bad !== 0)   begin failures++; $display("FAIL t1_pairs: got %0d bad expected 0", bad); end
      if (done_pulses !== 1) begin failures++; $display("FAIL t1_done_pulses: got %0d expected 1", done_pulses); end
   endtask

   task automatic test_offset_tile();
      int fw, dc, bad;
      logic b1;
      logic [31:0] base = 32'h0200_0000;
      fill_ram(0);
      do_start(6'd19, 6'd14, base);
      drain(0, -1, -1, fw, dc, b1);
      repeat (4) @(posedge clk);
      bad = count_bad(base, 19, 14);
      checks += 4;
      if (wa[0] !== base + 32'h0008_C4C0) begin failures++; $display("FAIL t2_first_addr: got %h expected %h", wa[0], base + 32'h0008_C4C0); end
      if (wa[1023] !== exp_addr(base, 19, 14, 1023)) begin failures++; $display("FAIL t2_last_addr: got %h expected %h", wa[1023], exp_addr(base, 19, 14, 1023)); end
      if (bad !== 0) begin failures++; $display("FAIL t2_pairs: got %0d bad expected 0", bad); end
      if (dc !== 1026) begin failures++; $display("FAIL t2_done_cycle: got %0d expected 1026", dc); end
   endtask

   task automatic test_random_wait();
      int fw, dc, bad;
      logic b1;
      fill_ram(1);
      do_start(6'd0, 6'd0, 32'h0010_0000);
      drain(1, -1, -1, fw, dc, b1);
      repeat (4) @(posedge clk);
      bad = count_bad(32'h0010_0000, 0, 0);
      checks += 4;
      if (dc < 0) begin failures++; $display("FAIL t3_timeout: got no done expected done"); end
      if (bad !== 0) begin failures++; $display("FAIL t3_pairs: got %0d bad expected 0", bad); end
      if (stall_viol !== 0) begin failures++; $display("FAIL t3_stall_stable: got %0d changes expected 0", stall_viol); end
      if (done_pulses !== 1) begin failures++; $display("FAIL t3_done_pulses: got %0d expected 1", done_pulses); end
   endtask

   task automatic test_long_stall();
      int fw, dc, bad;
      int max_ta = 0;
      logic b1;
      fill_ram(0);
      avm_waitrequest = 1'b1;
      do_start(6'd3, 6'd2, 32'h0004_0000);
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (int'(tile_addr) > max_ta) max_ta = int'(tile_addr);
      end
      checks += 5;
      if (tile_addr !== 10'd1) begin failures++; $display("FAIL t4_tile_addr: got %0d expected 1", tile_addr); end
      if (max_ta !== 1) begin failures++; $display("FAIL t4_max_read: got %0d expected 1", max_ta); end
      if (wa.size() !== 0) begin failures++; $display("FAIL t4_no_accept: got %0d expected 0", wa.size()); end
      drain(0, -1, -1, fw, dc, b1);
      repeat (4) @(posedge clk);
      bad = count_bad(32'h0004_0000, 3, 2);
      if (bad !== 0) begin failures++; $display("FAIL t4_pairs: got %0d bad expected 0", bad); end
      if (stall_viol !== 0) begin failures++; $display("FAIL t4_stall_stable: got %0d changes expected 0", stall_viol); end
   endtask

   task automatic test_restart_ignored();
      int fw, dc, bad;
      logic b1;
      fill_ram(0);
      do_start(6'd10, 6'd4, 32'h0030_0000);
      drain(0, 500, -1, fw, dc, b1);
      repeat (10) @(posedge clk);
      bad = count_bad(32'h0030_0000, 10, 4);
      checks += 3;
      if (wa.size() !== 1024) begin failures++; $display("FAIL t5_write_count: got %0d expected 1024", wa.size()); end
      if (bad !== 0) begin failures++; $display("FAIL t5_pairs: got %0d bad expected 0", bad); end
      if (done_pulses !== 1) begin failures++; $display("FAIL t5_done_pulses: got %0d expected 1", done_pulses); end
   endtask

   task automatic test_reset_mid_drain();
      int fw, dc, bad;
      logic b1;
      fill_ram(0);
      do_start(6'd1, 6'd1, 32'h0050_0000);
      drain(0, -1, 300, fw, dc, b1);
      #2;
      resetn = 1'b0;
      #1;
      checks += 5;
      if (avm_write !== 1'b0) begin failures++; $display("FAIL t6_async_write: got %b expected 0", avm_write); end
      if (busy !== 1'b0) begin failures++; $display("FAIL t6_async_busy: got %b expected 0", busy); end
      repeat (3) @(posedge clk);
      if (wa.size() !== 300) begin failures++; $display("FAIL t6_aborted_count: got %0d expected 300", wa.size()); end
      @(negedge clk);
      resetn = 1'b1;
      do_start(6'd2, 6'd5, 32'h0060_0000);
      drain(0, -1, -1, fw, dc, b1);
      repeat (4) @(posedge clk);
      bad = count_bad(32'h0060_0000, 2, 5);
      if (bad !== 0) begin failures++; $display("FAIL t6_pairs: got %0d bad expected 0", bad); end
      if (dc !== 1026) begin failures++; $display("FAIL t6_done_cycle: got %0d expected 1026", dc); end
   endtask

   initial begin
      test_reset();
      test_ramp_tile00();
      test_offset_tile();
      test_random_wait();
      test_long_stall();
      test_restart_ignored();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
